// File: rtl/smaesh_key_pkg.sv
// Shared types for the SMAesH key fetch front end.
// State encoding, key size codes and the key word count helper.
package smaesh_key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LASTKEY,
    DONE
  } state_t;

  localparam logic [1:0] KS128 = 2'b00;
  localparam logic [1:0] KS192 = 2'b01;
  localparam logic [1:0] KS256 = 2'b10;

  // Word count modulo 8: a 256-bit key yields 3'd0, so
  // nwords(size) - 1 still gives the last index (7).
  function automatic logic [2:0] nwords(
    input logic [1:0] size
  );
    logic [2:0] n;
    n = 3'd4;
    unique case (1'b1)
      (size == KS192): n = 3'd6;
      (size == KS256): n = 3'd0;
      default:         n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/smaesh_key_fetch.sv
// Key fetch front end of the SMAesH key scheduling unit.
// Ports: clk/rst; arbiter side start_fetch, valid_in, in_ready,
// key_data, cfg_size, cfg_inverse, busy; core side
// last_key_computation_required, last_key_done; key register
// side key_we, key_widx, key_wdata, key_nk, key_inverse,
// fetch_done.
module smaesh_key_fetch
  import smaesh_key_pkg::*;
#(
  parameter int d = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_fetch,
  input  logic            valid_in,
  output logic            in_ready,
  input  logic [32*d-1:0] key_data,
  input  logic [1:0]      cfg_size,
  input  logic            cfg_inverse,
  output logic            busy,
  output logic            last_key_computation_required,
  input  logic            last_key_done,
  output logic            key_we,
  output logic [2:0]      key_widx,
  output logic [32*d-1:0] key_wdata,
  output logic [1:0]      key_nk,
  output logic            key_inverse,
  output logic            fetch_done
);

  state_t     state;
  state_t     state_n;
  logic [2:0] cnt;
  logic [2:0] cnt_n;
  logic [2:0] last_idx;
  logic       accept;
  logic       start_acc;

  // Size comes straight from cfg while idle, latched after.
  assign last_idx = nwords(state == IDLE ? cfg_size
                                         : key_nk) - 3'd1;

  assign in_ready = ~rst &
                    ((state == IDLE) | (state == FETCH));

  assign start_acc = (state == IDLE) & start_fetch;

  assign accept = start_acc |
                  ((state == FETCH) & valid_in & in_ready);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start_fetch) begin
          state_n = FETCH;
          cnt_n   = 3'd1;
        end
      end
      FETCH: begin
        if (accept) begin
          if (cnt == last_idx) begin
            cnt_n   = 3'd0;
            state_n = key_inverse ? LASTKEY : DONE;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
      LASTKEY: begin
        if (last_key_done) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      busy        <= 1'b0;
      fetch_done  <= 1'b0;
      key_we      <= 1'b0;
      key_widx    <= 3'd0;
      key_wdata   <= '0;
      key_nk      <= KS128;
      key_inverse <= 1'b0;
      last_key_computation_required <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      busy       <= (state_n != IDLE);
      fetch_done <= (state_n == DONE);
      key_we     <= accept;
      last_key_computation_required <= (state_n == LASTKEY);
      if (accept) begin
        key_widx  <= cnt;
        key_wdata <= key_data;
      end
      if (start_acc) begin
        key_nk      <= (cfg_size == 2'b11) ? KS128
                                           : cfg_size;
        key_inverse <= cfg_inverse;
      end
    end
  end

endmodule
